dual_issue: RTL and testbench

//  Issue stage of the dual-issue CPU, directly downstream of dual decode.

---
 rtl/dual_issue.sv | 207 ++++++++++++++++++++
 tb/tb_dual_issue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dual_issue : issue stage for a dual-issue pipeline, splits RAW pairs  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module dual_issue #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             ex_stall,
    input  logic             dec_valid_0,
    input  logic [31:0]      dec_pc_0,
    input  logic [4:0]       dec_rs1_0,
    input  logic [4:0]       dec_rs2_0,
    input  logic [4:0]       dec_rd_0,
    input  logic [3:0]       dec_alu_op_0,
    input  logic [31:0]      dec_imm_0,
    input  logic             dec_has_rd_0,
    input  logic             dec_use_imm_0,
    input  logic             dec_valid_1,
    input  logic [31:0]      dec_pc_1,
    input  logic [4:0]       dec_rs1_1,
    input  logic [4:0]       dec_rs2_1,
    input  logic [4:0]       dec_rd_1,
    input  logic [3:0]       dec_alu_op_1,
    input  logic [31:0]      dec_imm_1,
    input  logic             dec_has_rd_1,
    input  logic             dec_use_imm_1,
    output logic             stall_dec,
    output logic             iss_valid_0,
    output logic [31:0]      iss_pc_0,
    output logic [4:0]       iss_rs1_0,
    output logic [4:0]       iss_rs2_0,
    output logic [4:0]       iss_rd_0,
    output logic [3:0]       iss_alu_op_0,
    output logic [31:0]      iss_imm_0,
    output logic             iss_has_rd_0,
    output logic             iss_use_imm_0,
    output logic             iss_valid_1,
    output logic [31:0]      iss_pc_1,
    output logic [4:0]       iss_rs1_1,
    output logic [4:0]       iss_rs2_1,
    output logic [4:0]       iss_rd_1,
    output logic [3:0]       iss_alu_op_1,
    output logic [31:0]      iss_imm_1,
    output logic             iss_has_rd_1,
    output logic             iss_use_imm_1,
    output logic [CNT_W-1:0] cnt_pair,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_split
);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic [31:0] imm;
        logic        has_rd;
        logic        use_imm;
    } slot_t;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_SPLIT  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    slot_t            w_slot0;
    slot_t            w_slot1;
    slot_t            r_lane0;
    slot_t            r_lane1;
    slot_t            w_lane0_nxt;
    slot_t            w_lane1_nxt;
    logic             r_v0;
    logic             r_v1;
    logic             w_v0_nxt;
    logic             w_v1_nxt;
    logic             w_split_evt;
    logic             w_haz;
    logic             w_advance;
    logic [CNT_W-1:0] r_cnt_pair;
    logic [CNT_W-1:0] r_cnt_single;
    logic [CNT_W-1:0] r_cnt_split;

    assign w_slot0 = '{pc: dec_pc_0, rs1: dec_rs1_0, rs2: dec_rs2_0, rd: dec_rd_0,
                       alu_op: dec_alu_op_0, imm: dec_imm_0,
                       has_rd: dec_has_rd_0, use_imm: dec_use_imm_0};
    assign w_slot1 = '{pc: dec_pc_1, rs1: dec_rs1_1, rs2: dec_rs2_1, rd: dec_rd_1,
                       alu_op: dec_alu_op_1, imm: dec_imm_1,
                       has_rd: dec_has_rd_1, use_imm: dec_use_imm_1};

    // Younger instruction reads what the older one writes in the same pair
    assign w_haz = dec_valid_0 & dec_valid_1 & dec_has_rd_0 & (dec_rd_0 != 5'd0) &
                   ((dec_rd_0 == dec_rs1_1) | (!dec_use_imm_1 & (dec_rd_0 == dec_rs2_1)));

    assign w_advance = !flush & !ex_stall;
    assign stall_dec = !flush & (ex_stall | ((r_state == ST_NORMAL) & w_haz));

    always_comb begin
        w_state_nxt = r_state;
        w_v0_nxt    = 1'b0;
        w_v1_nxt    = 1'b0;
        w_lane0_nxt = '0;
        w_lane1_nxt = '0;
        w_split_evt = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                if (w_haz) begin
                    w_v0_nxt    = 1'b1;
                    w_lane0_nxt = w_slot0;
                    w_split_evt = 1'b1;
                    w_state_nxt = ST_SPLIT;
                end else if (dec_valid_0) begin
                    w_v0_nxt    = 1'b1;
                    w_lane0_nxt = w_slot0;
                    if (dec_valid_1) begin
                        w_v1_nxt    = 1'b1;
                        w_lane1_nxt = w_slot1;
                    end
                end else if (dec_valid_1) begin
                    w_v0_nxt    = 1'b1;
                    w_lane0_nxt = w_slot1;
                end
            end
            ST_SPLIT: begin
                // Decode held the pair, so slot1 is still the younger half
                w_v0_nxt    = dec_valid_1;
                w_lane0_nxt = dec_valid_1 ? w_slot1 : '0;
                w_state_nxt = ST_NORMAL;
            end
            default: w_state_nxt = ST_NORMAL;
        endcase
        if (flush) begin
            w_state_nxt = ST_NORMAL;
        end else if (ex_stall) begin
            w_state_nxt = r_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_lane0 <= '0;
            r_lane1 <= '0;
        end else if (flush) begin
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_lane0 <= '0;
            r_lane1 <= '0;
        end else if (!ex_stall) begin
            r_v0    <= w_v0_nxt;
            r_v1    <= w_v1_nxt;
            r_lane0 <= w_lane0_nxt;
            r_lane1 <= w_lane1_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_pair   <= '0;
            r_cnt_single <= '0;
            r_cnt_split  <= '0;
        end else if (w_advance) begin
            r_cnt_pair   <= r_cnt_pair   + CNT_W'(w_v0_nxt & w_v1_nxt);
            r_cnt_single <= r_cnt_single + CNT_W'(w_v0_nxt ^ w_v1_nxt);
            r_cnt_split  <= r_cnt_split  + CNT_W'(w_split_evt);
        end
    end

    assign iss_valid_0   = r_v0;
    assign iss_pc_0      = r_lane0.pc;
    assign iss_rs1_0     = r_lane0.rs1;
    assign iss_rs2_0     = r_lane0.rs2;
    assign iss_rd_0      = r_lane0.rd;
    assign iss_alu_op_0  = r_lane0.alu_op;
    assign iss_imm_0     = r_lane0.imm;
    assign iss_has_rd_0  = r_lane0.has_rd;
    assign iss_use_imm_0 = r_lane0.use_imm;
    assign iss_valid_1   = r_v1;
    assign iss_pc_1      = r_lane1.pc;
    assign iss_rs1_1     = r_lane1.rs1;
    assign iss_rs2_1     = r_lane1.rs2;
    assign iss_rd_1      = r_lane1.rd;
    assign iss_alu_op_1  = r_lane1.alu_op;
    assign iss_imm_1     = r_lane1.imm;
    assign iss_has_rd_1  = r_lane1.has_rd;
    assign iss_use_imm_1 = r_lane1.use_imm;
    assign cnt_pair      = r_cnt_pair;
    assign cnt_single    = r_cnt_single;
    assign cnt_split     = r_cnt_split;

endmodule
`default_nettype wire

// File: tb/tb_dual_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dual_issue : directed and random checks of dual_issue vs a model   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_dual_issue;

    localparam int CW = 8;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic        has_rd;
        logic        use_imm;
    } ins_t;

    logic clk;
    logic rst_n;
    logic flush;
    logic ex_stall;
    ins_t d0;
    ins_t d1;

    logic          stall_dec;
    logic          iss_valid_0, iss_valid_1;
    logic [31:0]   iss_pc_0, iss_pc_1, iss_imm_0, iss_imm_1;
    logic [4:0]    iss_rs1_0, iss_rs1_1, iss_rs2_0, iss_rs2_1, iss_rd_0, iss_rd_1;
    logic [3:0]    iss_alu_op_0, iss_alu_op_1;
    logic          iss_has_rd_0, iss_has_rd_1, iss_use_imm_0, iss_use_imm_1;
    logic [CW-1:0] cnt_pair, cnt_single, cnt_split;

    int errors = 0;
    int checks = 0;

    ins_t          m_l0, m_l1;
    bit            m_split;
    logic [CW-1:0] m_pair, m_single, m_cs;
    bit            m_stall;

    dual_issue #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ex_stall(ex_stall),
        .dec_valid_0(d0.v), .dec_pc_0(d0.pc), .dec_rs1_0(d0.rs1), .dec_rs2_0(d0.rs2),
        .dec_rd_0(d0.rd), .dec_alu_op_0(d0.alu), .dec_imm_0(d0.imm),
        .dec_has_rd_0(d0.has_rd), .dec_use_imm_0(d0.use_imm),
        .dec_valid_1(d1.v), .dec_pc_1(d1.pc), .dec_rs1_1(d1.rs1), .dec_rs2_1(d1.rs2),
        .dec_rd_1(d1.rd), .dec_alu_op_1(d1.alu), .dec_imm_1(d1.imm),
        .dec_has_rd_1(d1.has_rd), .dec_use_imm_1(d1.use_imm),
        .stall_dec(stall_dec),
        .iss_valid_0(iss_valid_0), .iss_pc_0(iss_pc_0), .iss_rs1_0(iss_rs1_0),
        .iss_rs2_0(iss_rs2_0), .iss_rd_0(iss_rd_0), .iss_alu_op_0(iss_alu_op_0),
        .iss_imm_0(iss_imm_0), .iss_has_rd_0(iss_has_rd_0), .iss_use_imm_0(iss_use_imm_0),
        .iss_valid_1(iss_valid_1), .iss_pc_1(iss_pc_1), .iss_rs1_1(iss_rs1_1),
        .iss_rs2_1(iss_rs2_1), .iss_rd_1(iss_rd_1), .iss_alu_op_1(iss_alu_op_1),
        .iss_imm_1(iss_imm_1), .iss_has_rd_1(iss_has_rd_1), .iss_use_imm_1(iss_use_imm_1),
        .cnt_pair(cnt_pair), .cnt_single(cnt_single), .cnt_split(cnt_split)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ins_t mk(input bit v, input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input bit has_rd, input bit use_imm);
        ins_t r;
        r = '{v: v, pc: pc, rs1: rs1, rs2: rs2, rd: rd, alu: 4'h1, imm: imm,
              has_rd: has_rd, use_imm: use_imm};
        return r;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t r;
        r.v       = ($urandom % 4) != 0;
        r.pc      = $urandom;
        r.rs1     = 5'($urandom_range(0, 3));
        r.rs2     = 5'($urandom_range(0, 3));
        r.rd      = 5'($urandom_range(0, 3));
        r.alu     = 4'($urandom);
        r.imm     = $urandom;
        r.has_rd  = ($urandom % 4) != 0;
        r.use_imm = $urandom % 2;
        return r;
    endfunction

    function automatic bit haz(input ins_t a, input ins_t b);
        return a.v && b.v && a.has_rd && a.rd != 0 &&
               (a.rd == b.rs1 || (!b.use_imm && a.rd == b.rs2));
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic ins_t obs_lane0();
        return {iss_valid_0, iss_pc_0, iss_rs1_0, iss_rs2_0, iss_rd_0, iss_alu_op_0,
                iss_imm_0, iss_has_rd_0, iss_use_imm_0};
    endfunction

    function automatic ins_t obs_lane1();
        return {iss_valid_1, iss_pc_1, iss_rs1_1, iss_rs2_1, iss_rd_1, iss_alu_op_1,
                iss_imm_1, iss_has_rd_1, iss_use_imm_1};
    endfunction

    task automatic check_outputs();
        check("lane0", 128'(obs_lane0()), 128'(m_l0));
        check("lane1", 128'(obs_lane1()), 128'(m_l1));
        check("cnt_pair", 128'(cnt_pair), 128'(m_pair));
        check("cnt_single", 128'(cnt_single), 128'(m_single));
        check("cnt_split", 128'(cnt_split), 128'(m_cs));
    endtask

    // Model: list the instructions leaving this cycle, in program order
    task automatic model_update();
        ins_t q[$];
        if (flush) begin
            m_l0 = '0;
            m_l1 = '0;
            m_split = 0;
        end else if (!ex_stall) begin
            if (m_split) begin
                if (d1.v) q.push_back(d1);
                m_split = 0;
            end else if (haz(d0, d1)) begin
                q.push_back(d0);
                m_split = 1;
                m_cs++;
            end else begin
                if (d0.v) q.push_back(d0);
                if (d1.v) q.push_back(d1);
            end
            m_l0 = (q.size() > 0) ? q[0] : '0;
            m_l1 = (q.size() > 1) ? q[1] : '0;
            if (q.size() == 2) m_pair++;
            if (q.size() == 1) m_single++;
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 with outputs checked
    task automatic step(input bit fl, input bit exs);
        flush    = fl;
        ex_stall = exs;
        #1;
        m_stall = !fl && (exs || (!m_split && haz(d0, d1)));
        check("stall_dec", 128'(stall_dec), 128'(m_stall));
        model_update();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        d0       = '0;
        d1       = '0;
        flush    = 1'b0;
        ex_stall = 1'b0;
        m_l0 = '0; m_l1 = '0; m_split = 0;
        m_pair = '0; m_single = '0; m_cs = '0;
        #1;
        check("reset_outputs", 128'(obs_lane0()), 128'(0));
        check_outputs();
        check("reset_stall", 128'(stall_dec), 128'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    ins_t indep0, indep1, raw0, raw1;

    initial begin
        indep0 = mk(1, 32'h100, 5'd2, 5'd3, 5'd1, 32'd0, 1, 0);
        indep1 = mk(1, 32'h104, 5'd5, 5'd6, 5'd4, 32'd0, 1, 0);
        raw0   = mk(1, 32'h100, 5'd0, 5'd0, 5'd5, 32'd1, 1, 1);
        raw1   = mk(1, 32'h104, 5'd5, 5'd7, 5'd6, 32'd0, 1, 0);

        reset_dut();

        // Independent pair
        d0 = indep0; d1 = indep1;
        step(0, 0);
        check("indep_valid", 128'({iss_valid_1, iss_valid_0}), 128'(2'b11));
        check("indep_rd1", 128'(iss_rd_1), 128'(4));
        check("indep_cnt_pair", 128'(cnt_pair), 128'(1));
        check("indep_stall", 128'(m_stall), 128'(stall_dec));

        // RAW pair split over two cycles
        reset_dut();
        d0 = raw0; d1 = raw1;
        step(0, 0);
        check("raw_c1_rd0", 128'(iss_rd_0), 128'(5));
        check("raw_c1_v1", 128'(iss_valid_1), 128'(0));
        step(0, 0);
        check("raw_c2_rd0", 128'(iss_rd_0), 128'(6));
        check("raw_cnt_split", 128'(cnt_split), 128'(1));
        check("raw_cnt_single", 128'(cnt_single), 128'(2));

        // False hazards: x0 destination, immediate hides rs2
        reset_dut();
        d0 = mk(1, 32'h200, 5'd1, 5'd2, 5'd0, 32'd0, 1, 0);
        d1 = mk(1, 32'h204, 5'd0, 5'd4, 5'd3, 32'd0, 1, 0);
        step(0, 0);
        d0 = mk(1, 32'h208, 5'd1, 5'd2, 5'd5, 32'd0, 1, 0);
        d1 = mk(1, 32'h20c, 5'd1, 5'd5, 5'd6, 32'd7, 1, 1);
        step(0, 0);
        check("false_haz_split", 128'(cnt_split), 128'(0));
        check("false_haz_pair", 128'(cnt_pair), 128'(2));

        // Only slot1 valid compacts to lane0
        d0 = '0;
        d1 = mk(1, 32'h104, 5'd1, 5'd2, 5'd3, 32'd0, 1, 0);
        step(0, 0);
        check("compact_pc", 128'(iss_pc_0), 128'(32'h104));
        check("compact_valid", 128'({iss_valid_1, iss_valid_0}), 128'(2'b01));

        // ex_stall held three cycles while in SPLIT
        reset_dut();
        d0 = raw0; d1 = raw1;
        step(0, 0);
        repeat (3) begin
            step(0, 1);
            check("exs_frozen_rd0", 128'(iss_rd_0), 128'(5));
            check("exs_stall_dec", 128'(stall_dec), 128'(1));
        end
        step(0, 0);
        d0 = '0; d1 = '0;
        step(0, 0);
        check("exs_single_once", 128'(cnt_single), 128'(2));

        // Flush while in SPLIT
        reset_dut();
        d0 = raw0; d1 = raw1;
        step(0, 0);
        step(1, 0);
        check("flush_valid", 128'({iss_valid_1, iss_valid_0}), 128'(2'b00));
        d0 = indep0; d1 = indep1;
        step(0, 0);
        check("post_flush_valid", 128'({iss_valid_1, iss_valid_0}), 128'(2'b11));

        // Reset asserted mid-SPLIT
        d0 = raw0; d1 = raw1;
        step(0, 0);
        reset_dut();
        d0 = indep0; d1 = indep1;
        step(0, 0);
        check("post_reset_valid", 128'({iss_valid_1, iss_valid_0}), 128'(2'b11));

        // Random traffic; decode holds its pair whenever stalled
        m_stall = 0;
        for (int i = 0; i < 800; i++) begin
            if (!m_stall) begin
                d0 = rnd_ins();
                d1 = rnd_ins();
            end
            step(($urandom % 20) == 0, ($urandom % 6) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
